// File: rtl/icache_line_fill.sv
// Direct-mapped instruction cache with a single-line refill engine.
// A fetch is registered into a lookup stage and answered one cycle later on a hit.
// On a miss the whole line is requested from memory and refilled from word 0.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   fetch_req/fetch_addr    fetch request strobe and word-aligned byte address
//   fetch_ready             request can be accepted this cycle
//   fetch_valid/fetch_instr returned instruction word (one-cycle pulse)
//   fetch_err               one-cycle pulse when a refill was aborted
//   flush                   invalidate all lines
//   mem_cmd_*               line read command towards memory
//   mem_rd_*                read data FIFO from memory
module icache_line_fill #(
  parameter int unsigned ADDR_WIDTH = 30,
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned NUM_LINES  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_ready,
  output logic                  fetch_valid,
  output logic [31:0]           fetch_instr,
  output logic                  fetch_err,
  input  logic                  flush,
  output logic                  mem_cmd_en,
  output logic [2:0]            mem_cmd_instr,
  output logic [5:0]            mem_cmd_bl,
  output logic [ADDR_WIDTH-1:0] mem_cmd_byte_addr,
  input  logic                  mem_cmd_empty,
  input  logic                  mem_cmd_full,
  output logic                  mem_rd_en,
  input  logic [31:0]           mem_rd_data,
  input  logic                  mem_rd_full,
  input  logic                  mem_rd_empty,
  input  logic [6:0]            mem_rd_count,
  input  logic                  mem_rd_overflow,
  input  logic                  mem_rd_error
);

  localparam int unsigned OFF_W = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned WA_W  = ADDR_WIDTH - 2;
  localparam int unsigned TAG_W = WA_W - OFF_W - IDX_W;

  typedef enum logic [1:0] {IDLE, ISSUE, FILL} state_t;

  state_t                 state_q, state_d;
  logic [WA_W-1:0]        lk_addr_q;
  logic                   lk_valid_q;
  logic [OFF_W-1:0]       fill_cnt_q;
  logic                   flush_pend_q;
  logic                   deliver_q;
  logic                   err_q;
  logic [NUM_LINES-1:0]   valid_q;
  logic [TAG_W-1:0]       tag_mem  [NUM_LINES];
  logic [31:0]            data_mem [NUM_LINES][LINE_WORDS];

  logic [OFF_W-1:0]       lk_off;
  logic [IDX_W-1:0]       lk_idx;
  logic [TAG_W-1:0]       lk_tag;
  logic                   hit_c, miss_c, ready_c, cmd_en_c, rd_en_c;
  logic                   abort_c, pop_c, fill_done_c, flush_all_c;
  logic                   unused_c;

  // Lookup-stage address fields (word address, byte bits dropped)
  assign lk_off = lk_addr_q[OFF_W-1:0];
  assign lk_idx = lk_addr_q[OFF_W +: IDX_W];
  assign lk_tag = lk_addr_q[WA_W-1 -: TAG_W];

  // lk_valid_q can only be set while IDLE, so the hit needs no state qualifier
  assign hit_c = lk_valid_q && valid_q[lk_idx] && (tag_mem[lk_idx] == lk_tag);

  // Next-state and control strobes
  always_comb begin
    state_d     = state_q;
    miss_c      = 1'b0;
    ready_c     = 1'b0;
    cmd_en_c    = 1'b0;
    rd_en_c     = 1'b0;
    abort_c     = 1'b0;
    pop_c       = 1'b0;
    fill_done_c = 1'b0;
    flush_all_c = 1'b0;
    case (state_q)
      IDLE: begin
        miss_c      = lk_valid_q && !hit_c;
        ready_c     = !miss_c;
        flush_all_c = flush;
        if (miss_c) state_d = ISSUE;
      end
      ISSUE: begin
        cmd_en_c = !mem_cmd_full;
        if (!mem_cmd_full) state_d = FILL;
      end
      FILL: begin
        rd_en_c     = !mem_rd_empty;
        abort_c     = mem_rd_error || mem_rd_overflow;
        pop_c       = rd_en_c && !abort_c;
        fill_done_c = pop_c && (fill_cnt_q == OFF_W'(LINE_WORDS - 1));
        // A flush seen during the refill is applied once the refill ends
        flush_all_c = (fill_done_c || abort_c) && (flush_pend_q || flush);
        if (fill_done_c || abort_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, lookup stage and refill bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      lk_addr_q    <= '0;
      lk_valid_q   <= 1'b0;
      fill_cnt_q   <= '0;
      flush_pend_q <= 1'b0;
      deliver_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      lk_valid_q <= fetch_req && ready_c;
      if (fetch_req && ready_c) lk_addr_q <= fetch_addr[ADDR_WIDTH-1:2];
      deliver_q  <= fill_done_c;
      err_q      <= abort_c;
      if (miss_c)     fill_cnt_q <= '0;
      else if (pop_c) fill_cnt_q <= fill_cnt_q + OFF_W'(1);
      if (fill_done_c || abort_c)         flush_pend_q <= 1'b0;
      else if (flush && state_q != IDLE)  flush_pend_q <= 1'b1;
    end
  end

  // Valid bits: line invalid from fill start until the last word lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           valid_q <= '0;
    else if (flush_all_c) valid_q <= '0;
    else if (miss_c)      valid_q[lk_idx] <= 1'b0;
    else if (fill_done_c) valid_q[lk_idx] <= 1'b1;
  end

  // Tag and data arrays carry no reset
  always_ff @(posedge clk) begin
    if (pop_c)       data_mem[lk_idx][fill_cnt_q] <= mem_rd_data;
    if (fill_done_c) tag_mem[lk_idx] <= lk_tag;
  end

  // The lookup address is held through the refill, so one read port serves both
  assign fetch_instr       = data_mem[lk_idx][lk_off];
  assign fetch_ready       = ready_c;
  assign fetch_valid       = hit_c || deliver_q;
  assign fetch_err         = err_q;
  assign mem_cmd_en        = cmd_en_c;
  assign mem_rd_en         = rd_en_c;
  assign mem_cmd_instr     = 3'b001;
  assign mem_cmd_bl        = 6'(LINE_WORDS - 1);
  assign mem_cmd_byte_addr = {lk_addr_q[WA_W-1:OFF_W], {(OFF_W + 2){1'b0}}};

  assign unused_c = ^{mem_cmd_empty, mem_rd_full, mem_rd_count, fetch_addr[1:0]};

endmodule
